// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared sizes and sequencer state encoding
package fetch_sequencer_pkg;
    localparam int FS_ADDR_W = 5;
    localparam int FS_DATA_W = 32;
    typedef enum logic [1:0] {FS_IDLE, FS_LOAD, FS_RUN, FS_HALT} fs_state_t;
endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// fs_next_pc: redirect priority and end-of-program detection for the fetch pc
module fs_next_pc
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = FS_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect,
    output logic              last,
    output logic              out_of_range
);
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W:0]   inc;
    always_comb begin
        redirect     = !stall && (br_taken || jmp_valid);
        tgt          = br_taken ? br_target : jmp_target;
        inc          = {1'b0, pc} + (ADDR_W+1)'(1);
        last         = !stall && !redirect && inc == prog_len;
        out_of_range = redirect && {1'b0, tgt} >= prog_len;
        // pc freezes on any path into HALT
        next_pc      = (stall || last || out_of_range) ? pc : redirect ? tgt : inc[ADDR_W-1:0];
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: pc owner, program loader and IF/ID register for the instruction memory
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = FS_ADDR_W,
    parameter int DATA_W = FS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_mode,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(2 ** ADDR_W);

    fs_state_t         state, state_n;
    logic [ADDR_W-1:0] pc, next_pc;
    logic [ADDR_W:0]   load_ptr, prog_len;
    logic              accept, redirect, last, out_of_range;

    fs_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc(pc),
        .prog_len(prog_len),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .jmp_valid(jmp_valid),
        .jmp_target(jmp_target),
        .next_pc(next_pc),
        .redirect(redirect),
        .last(last),
        .out_of_range(out_of_range)
    );

    always_comb begin
        load_ready = state == FS_LOAD && load_ptr < FULL;
        accept     = load_valid && load_ready;
        imem_we    = accept;
        imem_waddr = load_ptr[ADDR_W-1:0];
        imem_wdata = accept ? load_data : '0;
        imem_addr  = pc;
        halted     = state == FS_HALT;
    end

    always_comb begin
        state_n = state;
        case (state)
            FS_IDLE: state_n = load_mode ? FS_LOAD : start ? (prog_len == '0 ? FS_HALT : FS_RUN) : FS_IDLE;
            FS_LOAD: state_n = load_mode ? FS_LOAD : FS_IDLE;
            FS_RUN:  state_n = (last || out_of_range) ? FS_HALT : FS_RUN;
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FS_IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            load_ptr <= '0;
            prog_len <= FULL;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            if (state == FS_IDLE && load_mode) load_ptr <= '0;
            if (state == FS_IDLE && !load_mode && start) pc <= '0;
            if (accept) load_ptr <= load_ptr + (ADDR_W+1)'(1);
            // a word accepted in the exit cycle still counts toward the program length
            if (state == FS_LOAD && !load_mode) prog_len <= load_ptr + (ADDR_W+1)'(accept);
            if (state == FS_RUN && !stall) begin
                pc       <= next_pc;
                if_valid <= !redirect;
                if (!redirect) begin
                    if_instr <= imem_instr;
                    if_pc    <= pc;
                end
            end
            if (state == FS_HALT) if_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks against a behavioural sequencer model
module tb_fetch_sequencer;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_HALT = 3;
    localparam logic [31:0] K = 32'h9E3779B1;

    logic        clk = 1'b0;
    logic        reset, start, load_mode, load_valid, load_ready;
    logic [31:0] load_data, imem_instr, imem_wdata, if_instr;
    logic [4:0]  imem_addr, imem_waddr, br_target, jmp_target, if_pc;
    logic        imem_we, stall, br_taken, jmp_valid, if_valid, halted;

    int n_asserts = 0, n_fails = 0;

    logic [31:0] salt, wr_mask, mem [32];
    logic        mem_clr;

    logic [31:0] em [32];
    int          m_st, m_pc, m_ptr, m_len, m_ifpc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] abc [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) wr_mask <= '0;
        else if (imem_we) begin
            mem[imem_waddr]     <= imem_wdata;
            wr_mask[imem_waddr] <= 1'b1;
        end
    end
    assign imem_instr = wr_mask[imem_addr] ? mem[imem_addr] : salt ^ (32'(imem_addr) * K);

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .load_mode(load_mode),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid),
        .jmp_target(jmp_target), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .halted(halted)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_update();
        int t;
        if (reset) begin
            m_st = S_IDLE; m_pc = 0; m_ptr = 0; m_len = 32; m_valid = 0; m_instr = 0; m_ifpc = 0;
        end else if (m_st == S_IDLE) begin
            if (load_mode) begin m_st = S_LOAD; m_ptr = 0; end
            else if (start) begin
                if (m_len == 0) m_st = S_HALT;
                else begin m_st = S_RUN; m_pc = 0; end
            end
        end else if (m_st == S_LOAD) begin
            if (load_valid && m_ptr < 32) begin em[m_ptr] = load_data; m_ptr++; end
            if (!load_mode) begin m_st = S_IDLE; m_len = m_ptr; end
        end else if (m_st == S_RUN) begin
            if (!stall && (br_taken || jmp_valid)) begin
                t = br_taken ? int'(br_target) : int'(jmp_target);
                m_valid = 0;
                if (t >= m_len) m_st = S_HALT;
                else m_pc = t;
            end else if (!stall) begin
                m_instr = em[m_pc]; m_ifpc = m_pc; m_valid = 1;
                if (m_pc + 1 == m_len) m_st = S_HALT;
                else m_pc = (m_pc + 1) % 32;
            end
        end else m_valid = 0;
    endtask

    task automatic check_all();
        bit rdy, we;
        rdy = m_st == S_LOAD && m_ptr < 32;
        we  = rdy && load_valid;
        chk("load_ready", load_ready, rdy);
        chk("imem_we", imem_we, we);
        if (we) begin
            chk("imem_waddr", imem_waddr, m_ptr);
            chk("imem_wdata", imem_wdata, load_data);
        end
        chk("halted", halted, m_st == S_HALT);
        chk("if_valid", if_valid, m_valid);
        if (m_valid) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ifpc);
        end
        if (m_st == S_RUN || m_st == S_HALT) chk("imem_addr", imem_addr, m_pc);
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic clear_in();
        start = 0; load_mode = 0; load_valid = 0; load_data = 0;
        stall = 0; br_taken = 0; br_target = 0; jmp_valid = 0; jmp_target = 0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1; step(); reset = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic run_to_halt(int lim);
        for (int i = 0; i < lim && m_st != S_HALT; i++) step();
        chk("halt_reached", halted, 1);
    endtask

    task automatic rnd_run(int lim);
        for (int i = 0; i < lim && m_st != S_HALT; i++) begin
            stall = $urandom % 5 == 0;
            br_taken = $urandom % 8 == 0;
            jmp_valid = $urandom % 8 == 0;
            br_target = 5'($urandom_range(0, 15));
            jmp_target = 5'($urandom_range(0, 31));
            step();
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        reset = 1; mem_clr = 1; salt = $urandom;
        for (int i = 0; i < 32; i++) em[i] = salt ^ (32'(i) * K);
        repeat (2) @(posedge clk);
        m_update();
        #1;
        mem_clr = 0;
        chk("rst_halted", halted, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        reset = 0;

        // full 32-word run without a load
        pulse_start();
        chk("start_ifv0", if_valid, 0);
        step();
        chk("start_ifv1", if_valid, 1);
        chk("start_pc0", if_pc, 0);
        run_to_halt(60);
        chk("full_last_pc", if_pc, 31);
        step(); step();

        // three-word program
        do_reset();
        for (int k = 0; k < 3; k++) abc[k] = $urandom;
        load_mode = 1; step();
        for (int k = 0; k < 3; k++) begin
            load_valid = 1; load_data = abc[k]; step();
        end
        load_valid = 0; load_mode = 0; step();
        chk("abc_mem0", mem[0], abc[0]);
        chk("abc_mem2", mem[2], abc[2]);
        pulse_start();
        run_to_halt(20);
        chk("abc_last_instr", if_instr, abc[2]);
        chk("abc_last_pc", if_pc, 2);
        step();

        // stall at pc 4 then simultaneous branch and jump
        do_reset();
        pulse_start();
        for (int i = 0; i < 20 && m_pc != 4; i++) step();
        chk("reach_pc4", imem_addr, 4);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imem_addr, 4);
            chk("stall_ifpc", if_pc, 3);
            chk("stall_ifv", if_valid, 1);
        end
        stall = 0; br_taken = 1; br_target = 10; jmp_valid = 1; jmp_target = 20;
        step();
        clear_in();
        chk("redir_ifv", if_valid, 0);
        chk("redir_addr", imem_addr, 10);
        step();
        chk("redir_ifpc", if_pc, 10);
        chk("redir_ifv1", if_valid, 1);
        rnd_run(80);

        // overfull load: the 33rd word is refused
        do_reset();
        load_mode = 1; step();
        for (int k = 0; k < 33; k++) begin
            if (k == 32) chk("ready_drop", load_ready, 0);
            load_valid = 1; load_data = $urandom; step();
        end
        load_valid = 0; load_mode = 0; step();
        pulse_start();
        run_to_halt(50);
        chk("len32_last_pc", if_pc, 31);

        // reset in the middle of a run
        do_reset();
        pulse_start();
        for (int i = 0; i < 20 && m_pc != 7; i++) step();
        chk("reach_pc7", imem_addr, 7);
        reset = 1; step(); reset = 0;
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_ifv", if_valid, 0);
        chk("mid_rst_addr", imem_addr, 0);
        step();
        chk("mid_rst_idle", if_valid, 0);

        // empty program halts straight from start
        do_reset();
        load_mode = 1; step();
        load_mode = 0; step();
        pulse_start();
        chk("empty_halt", halted, 1);
        step();

        // random programs with random stalls and redirects
        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 12);
            load_mode = 1; step();
            for (int k = 0; k < n; k++) begin
                load_valid = $urandom % 3 != 0;
                load_data = $urandom;
                load_mode = k != n - 1;
                step();
            end
            clear_in();
            pulse_start();
            rnd_run(150);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
